// File: rtl/avalon_enforcer_pkg.sv
// avalon_enforcer_pkg: shared types and sizing helpers for the Avalon-ST message enforcer
package avalon_enforcer_pkg;
    typedef enum logic {SOP_MERGE, SOP_TRUNCATE} sop_policy_t;
    typedef enum logic [1:0] {IDLE, IN_MSG, DISCARD} msg_sm_t;
    // one extra bit so out-of-range empty values can arrive and be clamped
    function automatic int empty_w(input int bytes);
        return $clog2(bytes) + 1;
    endfunction
endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST stream bundle with data/valid/rdy/sop/eop/empty
interface avalon_st_if import avalon_enforcer_pkg::*; #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EW = empty_w(DATA_WIDTH_IN_BYTES);
    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic valid;
    logic rdy;
    logic sop;
    logic eop;
    logic [EW-1:0] empty;
    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_skid_buffer.sv
// avalon_skid_buffer: 2-entry skid buffer with registered output and registered upstream ready
module avalon_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    output logic         in_rdy,
    output logic         out_valid,
    output logic [W-1:0] out_payload,
    input  logic         out_rdy
);
    logic         skid_v;
    logic         skid_v_n;
    logic [W-1:0] skid_p;
    // skid entry fills only when the output entry is occupied and stalled
    always_comb skid_v_n = skid_v ? !out_rdy : (in_valid && out_valid && !out_rdy);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_rdy      <= 1'b0;
            out_valid   <= 1'b0;
            out_payload <= '0;
            skid_v      <= 1'b0;
            skid_p      <= '0;
        end else begin
            in_rdy <= !skid_v_n;
            skid_v <= skid_v_n;
            if (skid_v) begin
                if (out_rdy) out_payload <= skid_p;
            end else if (in_valid) begin
                if (!out_valid || out_rdy) begin
                    out_payload <= in_payload;
                    out_valid   <= 1'b1;
                end else begin
                    skid_p <= in_payload;
                end
            end else if (out_rdy) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/avalon_enforcer_mc.sv
// avalon_enforcer_mc: repairs Avalon-ST framing (missing/unexpected SOP, overlong messages) and counts drops
module avalon_enforcer_mc import avalon_enforcer_pkg::*; #(
    parameter int          DATA_WIDTH_IN_BYTES = 16,
    parameter int          MAX_BEATS           = 256,
    parameter sop_policy_t SOP_POLICY          = SOP_MERGE,
    parameter int          CNT_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           untrusted_msg,
    avalon_st_if.master          enforced_msg,
    output logic                 missing_sop_indi,
    output logic                 unexpected_sop_indi,
    output logic                 too_long_indi,
    output logic [CNT_WIDTH-1:0] dropped_beats
);
    localparam int DBITS = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW    = empty_w(DATA_WIDTH_IN_BYTES);
    localparam int BW    = $clog2(MAX_BEATS + 1);
    localparam int PW    = DBITS + EW + 2;
    localparam logic [EW-1:0] EMAX = EW'(DATA_WIDTH_IN_BYTES - 1);
    localparam logic [BW-1:0] LAST = BW'(MAX_BEATS - 1);

    msg_sm_t       state, nxt;
    logic [BW-1:0] cnt, cnt_n;
    logic          acc, fwd, drop, miss, unexp, long_msg;
    logic          o_sop, o_eop;
    logic [EW-1:0] o_emp, emp_c;
    logic [DBITS-1:0] keep;
    logic [PW-1:0] out_p;

    assign acc   = untrusted_msg.valid && untrusted_msg.rdy;
    assign emp_c = (untrusted_msg.empty > EMAX) ? EMAX : untrusted_msg.empty;
    assign keep  = {DBITS{1'b1}} << {o_emp, 3'b000};

    always_comb begin
        nxt      = state;
        cnt_n    = cnt;
        fwd      = 1'b0;
        drop     = 1'b0;
        miss     = 1'b0;
        unexp    = 1'b0;
        long_msg = 1'b0;
        o_sop    = 1'b0;
        o_eop    = 1'b0;
        o_emp    = '0;
        if (acc) begin
            if (state != IN_MSG) begin
                fwd   = untrusted_msg.sop;
                drop  = !untrusted_msg.sop;
                miss  = !untrusted_msg.sop && state == IDLE;
                o_sop = 1'b1;
                o_eop = untrusted_msg.eop;
                o_emp = untrusted_msg.eop ? emp_c : '0;
                if (untrusted_msg.sop) begin
                    nxt   = untrusted_msg.eop ? IDLE : IN_MSG;
                    cnt_n = untrusted_msg.eop ? '0 : BW'(1);
                end
            end else begin
                fwd      = 1'b1;
                unexp    = untrusted_msg.sop;
                long_msg = cnt == LAST && !untrusted_msg.eop;
                // truncation closes the message with a full last beat
                if (long_msg || (untrusted_msg.sop && SOP_POLICY == SOP_TRUNCATE)) begin
                    o_eop = 1'b1;
                    nxt   = DISCARD;
                    cnt_n = '0;
                end else if (untrusted_msg.eop) begin
                    o_eop = 1'b1;
                    o_emp = emp_c;
                    nxt   = IDLE;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            dropped_beats       <= '0;
            missing_sop_indi    <= 1'b0;
            unexpected_sop_indi <= 1'b0;
            too_long_indi       <= 1'b0;
        end else begin
            state               <= nxt;
            cnt                 <= cnt_n;
            missing_sop_indi    <= miss;
            unexpected_sop_indi <= unexp;
            too_long_indi       <= long_msg;
            if (drop && !(&dropped_beats)) dropped_beats <= dropped_beats + 1'b1;
        end
    end

    avalon_skid_buffer #(.W(PW)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (fwd),
        .in_payload ({untrusted_msg.data & keep, o_sop, o_eop, o_emp}),
        .in_rdy     (untrusted_msg.rdy),
        .out_valid  (enforced_msg.valid),
        .out_payload(out_p),
        .out_rdy    (enforced_msg.rdy)
    );

    assign {enforced_msg.data, enforced_msg.sop, enforced_msg.eop, enforced_msg.empty} = out_p;
endmodule

// File: tb/tb_avalon_enforcer_mc.sv
// tb_avalon_enforcer_mc: scoreboard bench driving a SOP_MERGE and a SOP_TRUNCATE instance in parallel
module tb_avalon_enforcer_mc;
    import avalon_enforcer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [2:0]  in_empty = '0;
    logic        out_rdy = 1'b1;
    logic        miss_m, unexp_m, long_m, miss_t, unexp_t, long_t;
    logic [15:0] drop_m, drop_t;

    always #5 clk = ~clk;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) im ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) it ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) om ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) ot ();

    assign im.data = in_data;  assign im.valid = in_valid; assign im.sop = in_sop;
    assign im.eop = in_eop;    assign im.empty = in_empty;
    assign it.data = in_data;  assign it.valid = in_valid; assign it.sop = in_sop;
    assign it.eop = in_eop;    assign it.empty = in_empty;
    assign om.rdy = out_rdy;
    assign ot.rdy = out_rdy;

    avalon_enforcer_mc #(.DATA_WIDTH_IN_BYTES(4), .MAX_BEATS(4), .SOP_POLICY(SOP_MERGE), .CNT_WIDTH(16)) dut_m (
        .clk(clk), .rst(rst), .untrusted_msg(im), .enforced_msg(om),
        .missing_sop_indi(miss_m), .unexpected_sop_indi(unexp_m), .too_long_indi(long_m), .dropped_beats(drop_m));

    avalon_enforcer_mc #(.DATA_WIDTH_IN_BYTES(4), .MAX_BEATS(4), .SOP_POLICY(SOP_TRUNCATE), .CNT_WIDTH(16)) dut_t (
        .clk(clk), .rst(rst), .untrusted_msg(it), .enforced_msg(ot),
        .missing_sop_indi(miss_t), .unexpected_sop_indi(unexp_t), .too_long_indi(long_t), .dropped_beats(drop_t));

    int checks = 0, errors = 0;
    int n_miss_m = 0, n_unexp_m = 0, n_long_m = 0, n_miss_t = 0, n_unexp_t = 0, n_long_t = 0;
    logic [36:0] qm[$], qt[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xm(input logic [31:0] d, input logic s, input logic e, input logic [2:0] emp);
        qm.push_back({d, s, e, emp});
    endtask

    task automatic xt(input logic [31:0] d, input logic s, input logic e, input logic [2:0] emp);
        qt.push_back({d, s, e, emp});
    endtask

    task automatic xb(input logic [31:0] d, input logic s, input logic e, input logic [2:0] emp);
        xm(d, s, e, emp);
        xt(d, s, e, emp);
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [2:0] emp);
        int n = 0;
        in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(im.rdy && it.rdy) && n < 50);
        if (n >= 50) chk("send_timeout", {im.rdy, it.rdy}, 2'b11);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (om.valid && out_rdy) begin
                if (qm.size() == 0) chk("m_extra_beat", om.valid, 0);
                else chk("m_beat", {om.data, om.sop, om.eop, om.empty}, qm.pop_front());
            end
            if (ot.valid && out_rdy) begin
                if (qt.size() == 0) chk("t_extra_beat", ot.valid, 0);
                else chk("t_beat", {ot.data, ot.sop, ot.eop, ot.empty}, qt.pop_front());
            end
            n_miss_m += int'(miss_m); n_unexp_m += int'(unexp_m); n_long_m += int'(long_m);
            n_miss_t += int'(miss_t); n_unexp_t += int'(unexp_t); n_long_t += int'(long_t);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_rdy", {im.rdy, it.rdy}, 2'b00);
        chk("rst_out", {om.valid, om.data, ot.valid, ot.data}, 0);
        chk("rst_drop", {drop_m, drop_t}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_rst", {im.rdy, it.rdy}, 2'b11);

        // two back-to-back 3-beat messages
        xb(32'h01010101, 1, 0, 0); xb(32'h02020202, 0, 0, 0); xb(32'h03030303, 0, 1, 0);
        xb(32'h04040404, 1, 0, 0); xb(32'h05050505, 0, 0, 0); xb(32'h11223300, 0, 1, 1);
        send(32'h01010101, 1, 0, 0);
        chk("latency_1", {om.valid, om.data}, {1'b1, 32'h01010101});
        send(32'h02020202, 0, 0, 0); send(32'h03030303, 0, 1, 0);
        send(32'h04040404, 1, 0, 0); send(32'h05050505, 0, 0, 2); send(32'h11223344, 0, 1, 1);
        idle(4);
        chk("s1_drained", qm.size() + qt.size(), 0);
        chk("s1_no_ind", n_miss_m + n_unexp_m + n_long_m + n_miss_t + n_unexp_t + n_long_t, 0);

        // non-SOP beat while idle, then a good message
        send(32'hDEAD0001, 0, 0, 0);
        chk("s2_miss_pulse", {miss_m, miss_t}, 2'b11);
        xb(32'hA1A1A1A1, 1, 0, 0); xb(32'hA2A2A2A2, 0, 1, 0);
        send(32'hA1A1A1A1, 1, 0, 0); send(32'hA2A2A2A2, 0, 1, 0);
        idle(4);
        chk("s2_drop", {drop_m, drop_t}, {16'd1, 16'd1});
        chk("s2_miss_cnt", {n_miss_m[7:0], n_miss_t[7:0]}, {8'd1, 8'd1});
        chk("s2_drained", qm.size() + qt.size(), 0);

        // SOP on beat 2 of a 4-beat message
        xb(32'hB1B1B1B1, 1, 0, 0);
        xm(32'hB2B2B2B2, 0, 0, 0); xm(32'hB3B3B3B3, 0, 0, 0); xm(32'hB4B4B400, 0, 1, 1);
        xt(32'hB2B2B2B2, 0, 1, 0);
        send(32'hB1B1B1B1, 1, 0, 0); send(32'hB2B2B2B2, 1, 0, 0);
        send(32'hB3B3B3B3, 0, 0, 0); send(32'hB4B4B4B4, 0, 1, 1);
        idle(4);
        chk("s3_drop", {drop_m, drop_t}, {16'd1, 16'd3});
        chk("s3_unexp", {n_unexp_m[7:0], n_unexp_t[7:0]}, {8'd1, 8'd1});
        chk("s3_discard_silent", {n_miss_m[7:0], n_miss_t[7:0]}, {8'd1, 8'd1});
        chk("s3_drained", qm.size() + qt.size(), 0);

        // 6-beat message against MAX_BEATS=4
        xb(32'hC1C1C1C1, 1, 0, 0); xb(32'hC2C2C2C2, 0, 0, 0);
        xb(32'hC3C3C3C3, 0, 0, 0); xb(32'hC4C4C4C4, 0, 1, 0);
        send(32'hC1C1C1C1, 1, 0, 0); send(32'hC2C2C2C2, 0, 0, 0); send(32'hC3C3C3C3, 0, 0, 0);
        send(32'hC4C4C4C4, 0, 0, 2);
        chk("s4_long_pulse", {long_m, long_t}, 2'b11);
        send(32'hC5C5C5C5, 0, 0, 0); send(32'hC6C6C6C6, 0, 1, 1);
        idle(4);
        chk("s4_drop", {drop_m, drop_t}, {16'd3, 16'd5});
        chk("s4_long_cnt", {n_long_m[7:0], n_long_t[7:0]}, {8'd1, 8'd1});
        chk("s4_drained", qm.size() + qt.size(), 0);

        // empty masking and clamping
        xb(32'hAA000000, 1, 1, 3); xb(32'hAA000000, 1, 1, 3);
        xb(32'hD1D1D1D1, 1, 0, 0); xb(32'hD2D20000, 0, 1, 2);
        send(32'hAABBCCDD, 1, 1, 3); send(32'hAABBCCDD, 1, 1, 7);
        send(32'hD1D1D1D1, 1, 0, 0); send(32'hD2D2D2D2, 0, 1, 2);
        idle(4);
        chk("s5_drained", qm.size() + qt.size(), 0);

        // unexpected SOP on the MAX_BEATS-th beat, then a silent discard
        xb(32'hE1E1E1E1, 1, 0, 0); xb(32'hE2E2E2E2, 0, 0, 0);
        xb(32'hE3E3E3E3, 0, 0, 0); xb(32'hE4E4E4E4, 0, 1, 0);
        send(32'hE1E1E1E1, 1, 0, 0); send(32'hE2E2E2E2, 0, 0, 0);
        send(32'hE3E3E3E3, 0, 0, 0); send(32'hE4E4E4E4, 1, 0, 0);
        send(32'hE5E5E5E5, 0, 1, 0);
        idle(4);
        chk("s6_unexp", {n_unexp_m[7:0], n_unexp_t[7:0]}, {8'd2, 8'd2});
        chk("s6_long", {n_long_m[7:0], n_long_t[7:0]}, {8'd2, 8'd2});
        chk("s6_drop", {drop_m, drop_t}, {16'd4, 16'd6});
        chk("s6_no_miss", {n_miss_m[7:0], n_miss_t[7:0]}, {8'd1, 8'd1});
        chk("s6_drained", qm.size() + qt.size(), 0);

        // downstream stall for 5 cycles mid-message
        xb(32'hF1F1F1F1, 1, 0, 0); xb(32'hF2F2F2F2, 0, 0, 0);
        xb(32'hF3F3F3F3, 0, 0, 0); xb(32'hF4F4F4F4, 0, 1, 0);
        fork
            begin
                send(32'hF1F1F1F1, 1, 0, 0); send(32'hF2F2F2F2, 0, 0, 0);
                send(32'hF3F3F3F3, 0, 0, 0); send(32'hF4F4F4F4, 0, 1, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_rdy = 1'b0;
                @(posedge clk); #1;
                chk("s7_hold_a", {om.valid, om.data, ot.valid, ot.data}, {1'b1, 32'hF2F2F2F2, 1'b1, 32'hF2F2F2F2});
                repeat (3) @(posedge clk);
                #1;
                chk("s7_rdy_low", {im.rdy, it.rdy}, 2'b00);
                chk("s7_hold_b", {om.valid, om.data, ot.valid, ot.data}, {1'b1, 32'hF2F2F2F2, 1'b1, 32'hF2F2F2F2});
                @(posedge clk);
                #1 out_rdy = 1'b1;
            end
        join
        idle(6);
        chk("s7_drained", qm.size() + qt.size(), 0);

        // reset in the middle of a message
        xb(32'h61616161, 1, 0, 0); xb(32'h62626262, 0, 0, 0);
        send(32'h61616161, 1, 0, 0); send(32'h62626262, 0, 0, 0);
        idle(2);
        chk("s8_pre_drained", qm.size() + qt.size(), 0);
        #2 rst = 1'b1;
        #1;
        chk("s8_rst_out", {om.valid, om.data, om.sop, om.eop, om.empty, ot.valid, ot.sop, ot.eop}, 0);
        chk("s8_rst_misc", {im.rdy, it.rdy, drop_m, drop_t, miss_m, unexp_m, long_m}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        send(32'h71717171, 0, 1, 0);
        chk("s8_idle_miss", {miss_m, miss_t}, 2'b11);
        xb(32'h72727272, 1, 1, 0);
        send(32'h72727272, 1, 1, 0);
        idle(4);
        chk("s8_drop", {drop_m, drop_t}, {16'd1, 16'd1});
        chk("s8_drained", qm.size() + qt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
